wm_ctrl_prog: RTL and testbench
===============================

# wm_ctrl_prog

Parametrised, programmable washing-machine cycle controller; the next-generation sequencer for the washer front end. It runs a SOAK → WASH → RINSE (×N) → SPIN programme with per-phase durations loaded at start. A prescaled time-unit counter drives the phases, a lid-open pause freezes the programme, and coin return and cycle-complete outputs are handshaked. It sits between the panel/coin interface and the valve/motor drivers.

## Interface
- TIME_W, 8: width of phase durations and remaining-time counter (units).
- TICK_DIV, 4: clk cycles per time unit, ≥1.
- REP_W, 2: width of rinse repeat count.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- lid  input  1  1 = lid open.
- coin  input  1  coin accepted (level).
- cancel  input  1  abort request (level).
- start  input  1  start programme from READY.
- skip_soak  input  1  omit SOAK phase.
- rinse_reps  input  REP_W  number of rinse passes; 0 = no rinse.
- soak_time, wash_time, rinse_time, spin_time  input  TIME_W each  phase durations in units.
- idle_op, ready_op, soak_op, wash_op, rinse_op, spin_op  output  1 each  one-hot state indicators.
- paused  output  1  run state held by open lid.
- water_inlet  output  1  valve enable.
- motor_on  output  1  drum motor enable.
- coin_rtn  output  1  one-cycle coin-return pulse.
- cycle_done  output  1  one-cycle programme-complete pulse.
- remaining  output  TIME_W  units left in the current phase.
- rinse_idx  output  REP_W  current rinse pass, 0-based.

## Operation
- Reset (async, rst_n=0): state IDLE, remaining=0, rinse_idx=0, prescaler=0, coin_rtn=0, cycle_done=0, latched config=0. Outputs are valid during reset: idle_op=1, all other outputs 0.
- States: IDLE, READY, SOAK, WASH, RINSE, SPIN. SOAK/WASH/RINSE/SPIN are the run states.
- IDLE → READY when coin=1, lid=0, cancel=0; otherwise stay.
- READY + cancel=1 → IDLE, with coin_rtn=1 for exactly the first IDLE cycle.
- READY + start=1, lid=0, cancel=0: latch skip_soak, rinse_reps and the four times. Enter the first enabled phase with a nonzero duration. Later input changes are ignored until the next start.
- Phase enable and order: SOAK (disabled if skip_soak or time=0), WASH (time≠0), RINSE (reps≠0 and time≠0), SPIN (time≠0). Disabled phases are skipped in zero cycles.
- If no phase is enabled, READY → IDLE directly, with cycle_done pulsed.
- Phase entry: remaining ← phase time, prescaler ← 0.
- In each unpaused run cycle the prescaler increments. At TICK_DIV-1 it wraps to 0 and remaining decrements (a tick).
- A tick with remaining=1 ends the phase: load the next enabled phase at that edge. After the final SPIN tick, go to IDLE and pulse cycle_done in the first IDLE cycle.
- RINSE repeats: at the end of each pass, if rinse_idx < reps-1, then rinse_idx++ and remaining reloads to rinse_time, staying in RINSE. Otherwise leave RINSE. rinse_idx clears on any exit.
- Pause:
  - paused = run state & lid (combinational).
  - While paused, the prescaler and remaining freeze, and water_inlet=0, motor_on=0.
  - Closing the lid resumes from the frozen values.
- Cancel in any run state (paused or not) → IDLE at the next edge, with no coin_rtn and no cycle_done. Cancel has priority over a coincident phase-end tick.
- water_inlet = (SOAK|RINSE) & ~lid. motor_on = (WASH|RINSE|SPIN) & ~lid.
- remaining=0 and rinse_idx=0 in IDLE/READY.

## Timing
- All state, counters and pulses are registered. One-hot outputs follow state with no added latency. paused/water_inlet/motor_on are combinational on state and lid.
- An unpaused phase of duration T lasts exactly T·TICK_DIV cycles. Each paused cycle adds one cycle.
- Latency is 1 clk edge for: coin → READY, start → first phase, cancel → IDLE.
- coin_rtn and cycle_done are never high together and are each high for exactly one cycle.
- Reset asserted mid-phase aborts immediately. There is no pulse on the release of reset.
- remaining never underflows. It never wraps, at any TIME_W.

## Test plan
- TICK_DIV=4, times 1/2/2/2, reps=1, skip_soak=0: coin, then start → SOAK 4, WASH 8, RINSE 8, SPIN 8 cycles. IDLE with cycle_done=1 for 1 cycle, 28 cycles after SOAK entry.
- skip_soak=1, reps=2, rinse_time=1 → WASH directly; RINSE 4 cycles with rinse_idx=0, then 4 cycles with rinse_idx=1; then SPIN.
- lid=1 for 10 cycles mid-WASH (time 2) → paused=1, motor_on=0, remaining held; WASH totals 18 cycles. coin with lid=1 in IDLE → stays IDLE.
- cancel in READY → IDLE, coin_rtn=1 for one cycle. cancel on the final SPIN tick cycle → IDLE, cycle_done stays 0.
- All times 0 → READY→IDLE with cycle_done=1. rst_n=0 mid-RINSE → idle_op=1 and all other outputs 0 asynchronously.

Source files
------------

// File: rtl/wm_ctrl_prog.sv
// Programmable washer sequencer: SOAK, WASH, RINSE xN, SPIN.
// Phase times are loaded at start and counted in prescaled units.
module wm_ctrl_prog #(
  parameter int TIME_W   = 8,
  parameter int TICK_DIV = 4,
  parameter int REP_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lid,
  input  logic              coin,
  input  logic              cancel,
  input  logic              start,
  input  logic              skip_soak,
  input  logic [REP_W-1:0]  rinse_reps,
  input  logic [TIME_W-1:0] soak_time,
  input  logic [TIME_W-1:0] wash_time,
  input  logic [TIME_W-1:0] rinse_time,
  input  logic [TIME_W-1:0] spin_time,
  output logic              idle_op,
  output logic              ready_op,
  output logic              soak_op,
  output logic              wash_op,
  output logic              rinse_op,
  output logic              spin_op,
  output logic              paused,
  output logic              water_inlet,
  output logic              motor_on,
  output logic              coin_rtn,
  output logic              cycle_done,
  output logic [TIME_W-1:0] remaining,
  output logic [REP_W-1:0]  rinse_idx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_SOAK  = 3'd2;
  localparam logic [2:0] S_WASH  = 3'd3;
  localparam logic [2:0] S_RINSE = 3'd4;
  localparam logic [2:0] S_SPIN  = 3'd5;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [2:0]        r_state;
  logic [TIME_W-1:0] r_rem;
  logic [REP_W-1:0]  r_idx;
  logic [PW-1:0]     r_pre;
  logic              r_coin_rtn;
  logic              r_done;
  logic              r_skip;
  logic [REP_W-1:0]  r_reps;
  logic [TIME_W-1:0] r_tsoak;
  logic [TIME_W-1:0] r_twash;
  logic [TIME_W-1:0] r_trinse;
  logic [TIME_W-1:0] r_tspin;

  logic              w_ready;
  logic              w_run;
  logic              w_tick;
  logic              w_skip;
  logic [REP_W-1:0]  w_reps;
  logic [TIME_W-1:0] w_ts;
  logic [TIME_W-1:0] w_tw;
  logic [TIME_W-1:0] w_tr;
  logic [TIME_W-1:0] w_tsp;
  logic              w_c_soak;
  logic              w_c_wash;
  logic              w_c_rinse;
  logic              w_c_spin;
  logic              w_rep_more;
  logic [2:0]        w_nxt_st;
  logic [TIME_W-1:0] w_nxt_time;

  assign w_ready = (r_state == S_READY);
  assign w_run   = soak_op | wash_op | rinse_op | spin_op;
  assign w_tick  = w_run & ~lid & (r_pre == PRE_MAX);

  // At start the successor is chosen from the live inputs being latched.
  assign w_skip = w_ready ? skip_soak  : r_skip;
  assign w_reps = w_ready ? rinse_reps : r_reps;
  assign w_ts   = w_ready ? soak_time  : r_tsoak;
  assign w_tw   = w_ready ? wash_time  : r_twash;
  assign w_tr   = w_ready ? rinse_time : r_trinse;
  assign w_tsp  = w_ready ? spin_time  : r_tspin;

  assign w_c_soak  = w_ready & ~w_skip & (|w_ts);
  assign w_c_wash  = (w_ready | soak_op) & (|w_tw);
  assign w_c_rinse = (w_ready | soak_op | wash_op)
                   & (|w_reps) & (|w_tr);
  assign w_c_spin  = (w_ready | soak_op | wash_op | rinse_op)
                   & (|w_tsp);

  assign w_rep_more = ({1'b0, r_idx} + (REP_W+1)'(1))
                    < {1'b0, r_reps};

  // First enabled phase after the current one, IDLE when none remain.
  always_comb begin
    w_nxt_st   = S_IDLE;
    w_nxt_time = '0;
    if (w_c_soak) begin
      w_nxt_st   = S_SOAK;
      w_nxt_time = w_ts;
    end else if (w_c_wash) begin
      w_nxt_st   = S_WASH;
      w_nxt_time = w_tw;
    end else if (w_c_rinse) begin
      w_nxt_st   = S_RINSE;
      w_nxt_time = w_tr;
    end else if (w_c_spin) begin
      w_nxt_st   = S_SPIN;
      w_nxt_time = w_tsp;
    end
  end

  // Programme sequencer, unit counters and handshake pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_idx      <= '0;
      r_pre      <= '0;
      r_coin_rtn <= 1'b0;
      r_done     <= 1'b0;
      r_skip     <= 1'b0;
      r_reps     <= '0;
      r_tsoak    <= '0;
      r_twash    <= '0;
      r_trinse   <= '0;
      r_tspin    <= '0;
    end else begin
      r_coin_rtn <= 1'b0;
      r_done     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (coin & ~lid & ~cancel)
            r_state <= S_READY;
        end
        S_READY: begin
          if (cancel) begin
            r_state    <= S_IDLE;
            r_coin_rtn <= 1'b1;
          end else if (start & ~lid) begin
            r_skip   <= skip_soak;
            r_reps   <= rinse_reps;
            r_tsoak  <= soak_time;
            r_twash  <= wash_time;
            r_trinse <= rinse_time;
            r_tspin  <= spin_time;
            r_state  <= w_nxt_st;
            r_rem    <= w_nxt_time;
            r_pre    <= '0;
            r_idx    <= '0;
            if (w_nxt_st == S_IDLE)
              r_done <= 1'b1;
          end
        end
        S_SOAK, S_WASH, S_RINSE, S_SPIN: begin
          if (cancel) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_idx   <= '0;
            r_pre   <= '0;
          end else if (w_tick) begin
            r_pre <= '0;
            if (r_rem == TIME_W'(1)) begin
              if (rinse_op & w_rep_more) begin
                r_idx <= r_idx + REP_W'(1);
                r_rem <= r_trinse;
              end else begin
                r_state <= w_nxt_st;
                r_rem   <= w_nxt_time;
                r_idx   <= '0;
                if (w_nxt_st == S_IDLE)
                  r_done <= 1'b1;
              end
            end else begin
              r_rem <= r_rem - TIME_W'(1);
            end
          end else if (~lid) begin
            r_pre <= r_pre + PW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_rem   <= '0;
          r_idx   <= '0;
          r_pre   <= '0;
        end
      endcase
    end
  end

  assign idle_op     = (r_state == S_IDLE);
  assign ready_op    = (r_state == S_READY);
  assign soak_op     = (r_state == S_SOAK);
  assign wash_op     = (r_state == S_WASH);
  assign rinse_op    = (r_state == S_RINSE);
  assign spin_op     = (r_state == S_SPIN);
  assign paused      = w_run & lid;
  assign water_inlet = (soak_op | rinse_op) & ~lid;
  assign motor_on    = (wash_op | rinse_op | spin_op) & ~lid;
  assign coin_rtn    = r_coin_rtn;
  assign cycle_done  = r_done;
  assign remaining   = r_rem;
  assign rinse_idx   = r_idx;

endmodule

// File: tb/tb_wm_ctrl_prog.sv
// Bench for wm_ctrl_prog: phase-plan reference model,
// table-driven programmes, directed corners and random stimulus.
module tb_wm_ctrl_prog;

  localparam int TW = 8;
  localparam int TD = 4;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lid = 1'b0;
  logic          coin = 1'b0;
  logic          cancel = 1'b0;
  logic          start = 1'b0;
  logic          skip_soak = 1'b0;
  logic [RW-1:0] rinse_reps = '0;
  logic [TW-1:0] soak_time = '0;
  logic [TW-1:0] wash_time = '0;
  logic [TW-1:0] rinse_time = '0;
  logic [TW-1:0] spin_time = '0;
  logic          idle_op, ready_op, soak_op, wash_op, rinse_op, spin_op;
  logic          paused, water_inlet, motor_on, coin_rtn, cycle_done;
  logic [TW-1:0] remaining;
  logic [RW-1:0] rinse_idx;

  wm_ctrl_prog #(.TIME_W(TW), .TICK_DIV(TD), .REP_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .lid(lid), .coin(coin),
    .cancel(cancel), .start(start), .skip_soak(skip_soak),
    .rinse_reps(rinse_reps), .soak_time(soak_time),
    .wash_time(wash_time), .rinse_time(rinse_time),
    .spin_time(spin_time), .idle_op(idle_op), .ready_op(ready_op),
    .soak_op(soak_op), .wash_op(wash_op), .rinse_op(rinse_op),
    .spin_op(spin_op), .paused(paused), .water_inlet(water_inlet),
    .motor_on(motor_on), .coin_rtn(coin_rtn),
    .cycle_done(cycle_done), .remaining(remaining),
    .rinse_idx(rinse_idx)
  );

  always #5 clk = ~clk;

  logic [20:0] w_act;
  assign w_act = {idle_op, ready_op, soak_op, wash_op, rinse_op,
                  spin_op, paused, water_inlet, motor_on, coin_rtn,
                  cycle_done, remaining, rinse_idx};

  int checks = 0;
  int errors = 0;

  // Reference model: a list of timed passes built at start.
  typedef struct { int ph; int t; int idx; } item_t;
  item_t plan[$];
  int m_st, m_rem, m_idx, m_pre;
  bit m_rtn, m_done;

  task automatic model_reset();
    plan.delete();
    m_st = 0; m_rem = 0; m_idx = 0; m_pre = 0;
    m_rtn = 0; m_done = 0;
  endtask

  task automatic load_front();
    m_st  = plan[0].ph;
    m_rem = plan[0].t;
    m_idx = plan[0].idx;
    m_pre = 0;
  endtask

  task automatic model_step();
    m_rtn = 0;
    m_done = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_st)
      0: if (coin && !lid && !cancel) m_st = 1;
      1: begin
        if (cancel) begin
          m_st = 0;
          m_rtn = 1;
        end else if (start && !lid) begin
          plan.delete();
          if (!skip_soak && soak_time != 0)
            plan.push_back('{2, int'(soak_time), 0});
          if (wash_time != 0)
            plan.push_back('{3, int'(wash_time), 0});
          if (rinse_time != 0)
            for (int i = 0; i < int'(rinse_reps); i++)
              plan.push_back('{4, int'(rinse_time), i});
          if (spin_time != 0)
            plan.push_back('{5, int'(spin_time), 0});
          if (plan.size() == 0) begin
            m_st = 0;
            m_done = 1;
          end else load_front();
        end
      end
      default: begin
        if (cancel) begin
          plan.delete();
          m_st = 0; m_rem = 0; m_idx = 0; m_pre = 0;
        end else if (!lid) begin
          m_pre++;
          if (m_pre == TD) begin
            m_pre = 0;
            m_rem--;
            if (m_rem == 0) begin
              void'(plan.pop_front());
              if (plan.size() == 0) begin
                m_st = 0; m_idx = 0; m_done = 1;
              end else load_front();
            end
          end
        end
      end
    endcase
  endtask

  function automatic logic [20:0] expv();
    bit run;
    run = (m_st >= 2);
    return {m_st == 0, m_st == 1, m_st == 2, m_st == 3, m_st == 4,
            m_st == 5, run && lid, (m_st == 2 || m_st == 4) && !lid,
            (m_st >= 3) && !lid, m_rtn, m_done, TW'(m_rem),
            RW'(m_idx)};
  endfunction

  task automatic chk(string nm, logic [20:0] a, logic [20:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chki(string nm, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  task automatic cyc(string nm = "outputs");
    @(posedge clk);
    model_step();
    #1;
    chk(nm, w_act, expv());
  endtask

  task automatic go(bit sk, int rp, int ts, int tw, int tr, int tsp);
    lid = 0; cancel = 0;
    skip_soak = sk; rinse_reps = RW'(rp);
    soak_time = TW'(ts); wash_time = TW'(tw);
    rinse_time = TW'(tr); spin_time = TW'(tsp);
    coin = 1; cyc("coin");
    coin = 0; start = 1; cyc("start");
    start = 0;
    skip_soak = 1'($urandom); rinse_reps = RW'($urandom);
    soak_time = TW'($urandom); wash_time = TW'($urandom);
    rinse_time = TW'($urandom); spin_time = TW'($urandom);
  endtask

  task automatic run_to_idle(output int n);
    n = 0;
    while (!idle_op && n < 400) begin
      cyc();
      n++;
    end
  endtask

  typedef struct {
    bit sk; int rp; int ts; int tw; int tr; int tsp;
    logic [5:0] first; int ncyc;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int n;
    tbl[0] = '{0, 1, 1, 2, 2, 2, 6'b001000, 28};
    tbl[1] = '{1, 2, 5, 2, 1, 1, 6'b000100, 20};
    tbl[2] = '{0, 3, 0, 0, 3, 0, 6'b000010, 36};
    tbl[3] = '{0, 1, 0, 0, 0, 0, 6'b100000, 0};
    tbl[4] = '{0, 0, 2, 0, 5, 3, 6'b001000, 20};
    tbl[5] = '{1, 0, 3, 1, 2, 0, 6'b000100, 4};

    model_reset();
    #1;
    chk("reset", w_act, 21'h100000);
    cyc(); cyc();
    rst_n = 1;
    cyc("release");

    for (int i = 0; i < 6; i++) begin
      go(tbl[i].sk, tbl[i].rp, tbl[i].ts, tbl[i].tw,
         tbl[i].tr, tbl[i].tsp);
      chk($sformatf("first%0d", i), 21'(w_act[20:15]),
          21'(tbl[i].first));
      run_to_idle(n);
      chki($sformatf("dur%0d", i), n, tbl[i].ncyc);
      chki($sformatf("done%0d", i), int'(cycle_done), 1);
      cyc();
    end

    // Lid pause in a 2-unit WASH.
    go(1, 0, 0, 2, 0, 0);
    n = 0;
    repeat (3) begin cyc(); n++; end
    lid = 1;
    repeat (10) begin
      cyc("pause");
      n++;
    end
    chki("paused", int'({paused, motor_on}), 2);
    chki("held_rem", int'(remaining), 2);
    lid = 0;
    run_to_idle(n);
    chki("wash_pause", n + 13, 18);

    lid = 1; coin = 1;
    cyc("coin_lid");
    chki("coin_lid_idle", int'(idle_op), 1);
    lid = 0; coin = 0;

    // Cancel from READY returns the coin.
    coin = 1; cyc();
    coin = 0; cancel = 1; cyc("cancel_rdy");
    cancel = 0;
    chki("coin_rtn", int'({idle_op, coin_rtn}), 3);
    cyc();
    chki("coin_rtn_end", int'(coin_rtn), 0);

    // Cancel coincident with the final SPIN tick.
    go(1, 0, 0, 0, 0, 1);
    repeat (3) cyc();
    cancel = 1; cyc("cancel_spin");
    cancel = 0;
    chki("no_done", int'({idle_op, cycle_done}), 2);
    cyc();
    chki("no_done2", int'(cycle_done), 0);

    // Asynchronous reset mid-RINSE.
    go(1, 2, 0, 0, 2, 1);
    repeat (5) cyc();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("async_rst", w_act, 21'h100000);
    cyc();
    rst_n = 1;
    cyc("rst_release");

    // Randomised traffic against the model.
    for (int k = 0; k < 2500; k++) begin
      coin = ($urandom % 4) == 0;
      start = ($urandom % 3) == 0;
      cancel = ($urandom % 60) == 0;
      lid = ($urandom % 9) == 0;
      skip_soak = 1'($urandom);
      rinse_reps = RW'($urandom);
      soak_time = TW'($urandom_range(0, 3));
      wash_time = TW'($urandom_range(0, 3));
      rinse_time = TW'($urandom_range(0, 3));
      spin_time = TW'($urandom_range(0, 3));
      cyc("random");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
